// File: rtl/pipe_credit_sink.sv
// Credit-based receive buffer at the tail of a fixed-latency, non-stallable pipeline.
// Upstream spends one credit per launched word; each downstream pop returns one.
module pipe_credit_sink #(
  parameter int DATA_WIDTH = 8,
  parameter int LEVEL      = 2,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_issue,
  output logic                         s_credit_ok,
  output logic [$clog2(DEPTH+1)-1:0]   credit_cnt,
  input  logic                         din_valid,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         err_overflow,
  output logic                         err_credit
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Every in-flight word needs a slot, plus one to cover the pop-to-credit delay.
  generate
    if (DEPTH < LEVEL + 1) begin : g_depth_check
      $error("pipe_credit_sink: DEPTH must be at least LEVEL+1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [CW-1:0]         credit_reg;
  logic                  err_overflow_reg;
  logic                  err_credit_reg;

  logic issue;
  logic pop;
  logic full;
  logic wr_en;
  logic drop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign s_credit_ok  = (credit_reg != '0);
  assign credit_cnt   = credit_reg;
  assign m_valid      = (count_reg != '0);
  assign m_data       = m_valid ? mem[rd_ptr_reg] : '0;
  assign err_overflow = err_overflow_reg;
  assign err_credit   = err_credit_reg;

  always_comb begin
    issue = s_issue && s_credit_ok;
    pop   = m_valid && m_ready;
    full  = (count_reg == CW'(DEPTH));
    // A full buffer still takes a word when the head leaves in the same cycle.
    wr_en = din_valid && (!full || pop);
    drop  = din_valid && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_reg       <= CW'(DEPTH);
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      err_overflow_reg <= 1'b0;
      err_credit_reg   <= 1'b0;
    end else begin
      if (issue && !pop) begin
        credit_reg <= credit_reg - 1'b1;
      end else if (pop && !issue) begin
        credit_reg <= credit_reg + 1'b1;
      end

      if (wr_en) begin
        wr_ptr_reg <= next_ptr(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= next_ptr(rd_ptr_reg);
      end

      if (wr_en && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !wr_en) begin
        count_reg <= count_reg - 1'b1;
      end

      if (drop) begin
        err_overflow_reg <= 1'b1;
      end
      if (s_issue && !s_credit_ok) begin
        err_credit_reg <= 1'b1;
      end
    end
  end

  // Storage carries no reset; validity is tracked solely by count_reg.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr_reg] <= din;
    end
  end

endmodule

// File: tb/tb_pipe_credit_sink.sv
// Bench for pipe_credit_sink: a LEVEL-deep delay line models the feeding pipeline,
// a queue holds the words accepted upstream and a monitor checks every pop against it.
module tb_pipe_credit_sink;

  localparam int DW    = 8;
  localparam int LEVEL = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_issue;
  logic          s_credit_ok;
  logic [2:0]    credit_cnt;
  logic          din_valid;
  logic [DW-1:0] din;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          err_overflow;
  logic          err_credit;

  logic [DW-1:0] issue_data;
  logic          force_v;
  logic [DW-1:0] force_d;
  logic [LEVEL-1:0] pipe_v;
  logic [DW-1:0] pipe_d [LEVEL];

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_d;

  always #5 clk = ~clk;

  pipe_credit_sink #(.DATA_WIDTH(DW), .LEVEL(LEVEL), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s_issue(s_issue), .s_credit_ok(s_credit_ok),
    .credit_cnt(credit_cnt), .din_valid(din_valid), .din(din),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err_overflow(err_overflow), .err_credit(err_credit)
  );

  // Feeding pipeline: launches only when upstream holds a credit.
  always @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= s_issue && s_credit_ok;
      pipe_d[0] <= issue_data;
      for (int i = 1; i < LEVEL; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      if (s_issue && s_credit_ok) exp_q.push_back(issue_data);
    end
  end

  assign din_valid = pipe_v[LEVEL-1] | force_v;
  assign din       = force_v ? force_d : pipe_d[LEVEL-1];

  // Scoreboard monitor: every pop must deliver the oldest accepted word.
  always begin
    @(negedge clk);
    #1;
    if (rst === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
      n_checks++;
      pops++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_pop: got m_data=%02h, required no word", m_data);
      end else begin
        exp_d = exp_q.pop_front();
        if (m_data !== exp_d) begin
          n_fail++;
          $display("FAIL scoreboard_pop: got m_data=%02h, required %02h", m_data, exp_d);
        end else begin
          $display("pop m_data=%02h ok", m_data);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_issue = 1'b0; m_ready = 1'b0; force_v = 1'b0; force_d = '0; issue_data = '0;
    tick();
    // Inputs toggled during reset must be ignored.
    s_issue = 1'b1; m_ready = 1'b1; force_v = 1'b1; force_d = 8'hEE;
    tick();
    rst = 1'b0; s_issue = 1'b0; m_ready = 1'b0; force_v = 1'b0;
    tick();
    n_checks++; if (credit_cnt !== 3'd4) begin n_fail++; $display("FAIL reset_credit: got %0d required 4", credit_cnt); end
    n_checks++; if (s_credit_ok !== 1'b1) begin n_fail++; $display("FAIL reset_credit_ok: got %b required 1", s_credit_ok); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %02h required 00", m_data); end
    n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_err_overflow: got %b required 0", err_overflow); end
    n_checks++; if (err_credit !== 1'b0) begin n_fail++; $display("FAIL reset_err_credit: got %b required 0", err_credit); end
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_issue = 1'b1; issue_data = DW'(8'h11 * (i + 1));
      tick();
      n_checks++; if (credit_cnt !== 3'(3 - i)) begin n_fail++; $display("FAIL fill_credit[%0d]: got %0d required %0d", i, credit_cnt, 3 - i); end
    end
    s_issue = 1'b0;
    n_checks++; if (s_credit_ok !== 1'b0) begin n_fail++; $display("FAIL fill_credit_ok: got %b required 0", s_credit_ok); end
    tick(); tick();
    n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h11) begin n_fail++; $display("FAIL fill_head: got v=%b d=%02h required v=1 d=11", m_valid, m_data); end
    n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_overflow: got %b required 0", err_overflow); end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (credit_cnt !== 3'(i + 1)) begin n_fail++; $display("FAIL drain_credit[%0d]: got %0d required %0d", i, credit_cnt, i + 1); end
    end
    m_ready = 1'b0;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got m_valid=%b required 0", m_valid); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drain_scoreboard: got %0d left required 0", exp_q.size()); end
    $display("test_fill_drain done");
  endtask

  task automatic test_stream();
    int pops0;
    pops0 = pops;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (m_valid !== ((i >= 3 && i < 19) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL stream_latency[%0d]: got m_valid=%b required %b", i, m_valid, (i >= 3 && i < 19));
      end
      if (i < 16) begin
        n_checks++; if (s_credit_ok !== 1'b1) begin n_fail++; $display("FAIL stream_credit_ok[%0d]: got %b required 1", i, s_credit_ok); end
        s_issue = 1'b1; issue_data = DW'(i);
      end else begin
        s_issue = 1'b0;
      end
      tick();
    end
    m_ready = 1'b0;
    n_checks++; if (pops - pops0 != 16) begin n_fail++; $display("FAIL stream_pops: got %0d required 16", pops - pops0); end
    n_checks++; if (credit_cnt !== 3'd4) begin n_fail++; $display("FAIL stream_credit_end: got %0d required 4", credit_cnt); end
    $display("test_stream done");
  endtask

  task automatic test_credit_boundary();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_issue = 1'b1; issue_data = DW'(8'h30 + i);
      tick();
    end
    s_issue = 1'b0;
    tick(); tick();
    n_checks++; if (credit_cnt !== 3'd1 || m_valid !== 1'b1) begin n_fail++; $display("FAIL bound_setup: got credit=%0d v=%b required 1/1", credit_cnt, m_valid); end
    s_issue = 1'b1; issue_data = 8'h33; m_ready = 1'b1;
    tick();
    n_checks++; if (credit_cnt !== 3'd1) begin n_fail++; $display("FAIL bound_issue_pop: got %0d required 1", credit_cnt); end
    s_issue = 1'b1; issue_data = 8'h34; m_ready = 1'b0;
    tick();
    s_issue = 1'b0;
    n_checks++; if (credit_cnt !== 3'd0 || s_credit_ok !== 1'b0) begin n_fail++; $display("FAIL bound_zero: got credit=%0d ok=%b required 0/0", credit_cnt, s_credit_ok); end
    tick(); tick(); tick();
    m_ready = 1'b1;
    #1;
    n_checks++; if (s_credit_ok !== 1'b0) begin n_fail++; $display("FAIL bound_no_bypass: got %b required 0", s_credit_ok); end
    tick();
    n_checks++; if (s_credit_ok !== 1'b1 || credit_cnt !== 3'd1) begin n_fail++; $display("FAIL bound_return: got ok=%b credit=%0d required 1/1", s_credit_ok, credit_cnt); end
    repeat (3) tick();
    m_ready = 1'b0;
    n_checks++; if (credit_cnt !== 3'd4 || exp_q.size() != 0) begin n_fail++; $display("FAIL bound_end: got credit=%0d left=%0d required 4/0", credit_cnt, exp_q.size()); end
    $display("test_credit_boundary done");
  endtask

  task automatic test_overflow();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_issue = 1'b1; issue_data = DW'(8'h61 + i);
      tick();
    end
    s_issue = 1'b0;
    n_checks++; if (credit_cnt !== 3'd0) begin n_fail++; $display("FAIL ovf_setup_credit: got %0d required 0", credit_cnt); end
    tick(); tick();
    n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b required 0", err_overflow); end
    force_v = 1'b1; force_d = 8'h55;
    tick();
    force_v = 1'b0;
    n_checks++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b required 1", err_overflow); end
    s_issue = 1'b1; issue_data = 8'h77;
    tick();
    s_issue = 1'b0;
    n_checks++; if (err_credit !== 1'b1) begin n_fail++; $display("FAIL credit_err_set: got %b required 1", err_credit); end
    n_checks++; if (credit_cnt !== 3'd0) begin n_fail++; $display("FAIL credit_err_cnt: got %0d required 0", credit_cnt); end
    tick(); tick();
    n_checks++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b required 1", err_overflow); end
    m_ready = 1'b1;
    repeat (4) tick();
    m_ready = 1'b0;
    n_checks++; if (m_valid !== 1'b0 || credit_cnt !== 3'd4) begin n_fail++; $display("FAIL ovf_drain: got v=%b credit=%0d required 0/4", m_valid, credit_cnt); end
    n_checks++; if (err_overflow !== 1'b1 || err_credit !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got ovf=%b cred=%b required 1/1", err_overflow, err_credit); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_scoreboard: got %0d left required 0", exp_q.size()); end
    $display("test_overflow done");
  endtask

  task automatic test_reset_mid();
    int pops0;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_issue = 1'b1; issue_data = DW'(8'h91 + i);
      tick();
    end
    s_issue = 1'b0;
    tick(); tick();
    n_checks++; if (credit_cnt !== 3'd1 || m_valid !== 1'b1) begin n_fail++; $display("FAIL mid_setup: got credit=%0d v=%b required 1/1", credit_cnt, m_valid); end
    rst = 1'b1; s_issue = 1'b1; m_ready = 1'b1; force_v = 1'b1; force_d = 8'h5A;
    exp_q.delete();
    tick();
    rst = 1'b0; s_issue = 1'b0; m_ready = 1'b0; force_v = 1'b0;
    n_checks++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_valid: got v=%b d=%02h required 0/00", m_valid, m_data); end
    n_checks++; if (credit_cnt !== 3'd4) begin n_fail++; $display("FAIL mid_rst_credit: got %0d required 4", credit_cnt); end
    n_checks++; if (err_overflow !== 1'b0 || err_credit !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags: got ovf=%b cred=%b required 0/0", err_overflow, err_credit); end
    pops0 = pops;
    m_ready = 1'b1;
    s_issue = 1'b1; issue_data = 8'hA0; tick();
    s_issue = 1'b1; issue_data = 8'hA1; tick();
    s_issue = 1'b0;
    repeat (4) tick();
    m_ready = 1'b0;
    n_checks++; if (pops - pops0 != 2 || exp_q.size() != 0) begin n_fail++; $display("FAIL mid_fresh: got pops=%0d left=%0d required 2/0", pops - pops0, exp_q.size()); end
    $display("test_reset_mid done");
  endtask

  initial begin
    rst = 1'b1; s_issue = 1'b0; m_ready = 1'b0; force_v = 1'b0; force_d = '0; issue_data = '0;
    test_reset();
    test_fill_drain();
    test_stream();
    test_credit_boundary();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_credit_sink.md
PIPE_CREDIT_SINK -- requirements
Module: pipe_credit_sink

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of the data word.
REQ-002 SHALL have parameter LEVEL, default 2, latency in cycles of the non-stallable pipeline feeding din.
REQ-003 SHALL have parameter DEPTH, default 4, number of receive buffer entries; elaboration SHALL fail if DEPTH < LEVEL+1.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 s_issue  input  1  upstream launched one word into the feeding pipeline this cycle.
REQ-007 s_credit_ok  output  1  upstream may assert s_issue this cycle.
REQ-008 credit_cnt  output  clog2(DEPTH+1)  current credit count.
REQ-009 din_valid  input  1  pipeline output word valid.
REQ-010 din  input  DATA_WIDTH  pipeline output word.
REQ-011 m_valid  output  1  buffered word available downstream.
REQ-012 m_ready  input  1  downstream accepts word.
REQ-013 m_data  output  DATA_WIDTH  head-of-buffer word.
REQ-014 err_overflow  output  1  sticky: din_valid arrived while buffer full.
REQ-015 err_credit  output  1  sticky: s_issue asserted while s_credit_ok low.

Function
REQ-016 Credit counter SHALL start at DEPTH; s_credit_ok SHALL equal (credit_cnt != 0), combinational from the register.
REQ-017 Issue = s_issue && s_credit_ok; pop = m_valid && m_ready.
REQ-018 Next credit_cnt: issue only -> -1; pop only -> +1; both or neither -> unchanged.
REQ-019 Credit freed by a pop SHALL become visible on s_credit_ok the following cycle (no same-cycle bypass).
REQ-020 s_issue while s_credit_ok=0 SHALL set err_credit and leave credit_cnt unchanged.
REQ-021 Buffer SHALL be a circular FIFO of DEPTH entries; rd/wr pointers wrap from DEPTH-1 to 0 (DEPTH need not be a power of two).
REQ-022 din_valid with buffer not full SHALL write din at wr_ptr; word visible on m_valid/m_data the next cycle (1-cycle latency, no fall-through).
REQ-023 din_valid with buffer full and no pop in the same cycle SHALL drop din, set err_overflow, leave occupancy unchanged.
REQ-024 din_valid with buffer full and simultaneous pop SHALL be accepted (write and read both occur, occupancy unchanged).
REQ-025 Simultaneous write and pop on non-full, non-empty buffer SHALL keep occupancy constant.
REQ-026 m_valid SHALL equal (occupancy != 0); m_data SHALL equal entry at rd_ptr when m_valid=1 and 0 when m_valid=0.
REQ-027 m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-028 Order SHALL be preserved: words leave in din arrival order.
REQ-029 With m_ready held 1 and s_issue every cycle, throughput SHALL be one word per cycle with s_credit_ok never deasserting.
REQ-030 err_overflow and err_credit SHALL clear only on rst.

Reset
REQ-031 On rst: credit_cnt=DEPTH, s_credit_ok=1, m_valid=0, m_data=0, pointers=0, occupancy=0, err_overflow=0, err_credit=0.
REQ-032 While rst=1, s_issue, din_valid and m_ready SHALL be ignored; reset mid-operation discards all buffered words.
REQ-033 Buffer storage SHALL not need reset; only control state and outputs.

Verification (DATA_WIDTH=8, LEVEL=2, DEPTH=4)
REQ-034 Reset release -> credit_cnt=4, s_credit_ok=1, m_valid=0, m_data=0x00, both err flags 0.
REQ-035 m_ready=0, issue 0x11,0x22,0x33,0x44 on 4 cycles -> credit_cnt 3,2,1,0; s_credit_ok=0 after 4th; words arrive 2 cycles later; occupancy 4; then m_ready=1 -> 0x11..0x44 out one per cycle, credit_cnt 1,2,3,4.
REQ-036 m_ready=1, issue 0x00..0x0F every cycle -> s_credit_ok stays 1, m_data sequence 0x00..0x0F in order, each 1 cycle after its din_valid.
REQ-037 credit_cnt=1, issue and pop same cycle -> credit_cnt stays 1; credit_cnt=0 with pop -> s_credit_ok=1 next cycle, not same cycle.
REQ-038 Buffer full, m_ready=0, force din_valid=1 din=0x55 -> err_overflow=1 sticky, 0x55 never appears; s_issue at credit_cnt=0 -> err_credit=1, credit_cnt stays 0.
REQ-039 rst pulsed with 3 words buffered and credit_cnt=1 -> next cycle m_valid=0, credit_cnt=4, flags 0; fresh stream 0xA0,0xA1 delivered correctly.
